// File: rtl/btn_debounce_sync.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce_sync
// Purpose  : Two-flop synchronizer plus per-channel debounce for button pads,
//            producing debounced levels and one-cycle press/release pulses.
//            Optional auto-repeat of btn_press: BTN_DEBOUNCE_AUTOREPEAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module btn_debounce_sync #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 50,
  parameter int unsigned REPEAT_CYCLES   = 100000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] btn_raw,
  output logic [WIDTH-1:0] btn_level,
  output logic [WIDTH-1:0] btn_press,
  output logic [WIDTH-1:0] btn_release,
  output logic             any_press
);

  localparam int unsigned          c_CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_CNT_W-1:0]   c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
  localparam int unsigned          c_REP_W   = $clog2(REPEAT_CYCLES);
  localparam logic [c_REP_W-1:0]   c_REP_MAX = c_REP_W'(REPEAT_CYCLES - 1);
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = (REPEAT_CYCLES == 0);
`endif

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    logic [c_CNT_W-1:0] cnt_q, cnt_d;
    logic               level_q, level_d;
    logic               press_q, press_d;
    logic               release_q, release_d;
    logic               accept;
    logic               rep_fire;

    // Counter only runs while the synchronized input disagrees with the level.
    always_comb begin
      cnt_d  = cnt_q;
      accept = 1'b0;
      if (sync2_q[i] == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == c_CNT_MAX) begin
        cnt_d  = '0;
        accept = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      level_d   = accept ? sync2_q[i] : level_q;
      press_d   = (accept & sync2_q[i]) | rep_fire;
      release_d = accept & ~sync2_q[i];
    end

`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
    logic [c_REP_W-1:0] rep_q, rep_d;

    // Phase restarts on every accepted edge; repeats fire only while held.
    always_comb begin
      rep_d    = rep_q + 1'b1;
      rep_fire = 1'b0;
      if (!level_q || accept) begin
        rep_d = '0;
      end else if (rep_q == c_REP_MAX) begin
        rep_d    = '0;
        rep_fire = 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) rep_q <= '0;
      else     rep_q <= rep_d;
    end
`else
    assign rep_fire = 1'b0;
`endif

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q     <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        cnt_q     <= cnt_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
      end
    end

    assign btn_level[i]   = level_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = release_q;
  end

  assign any_press = |btn_press;

endmodule
`default_nettype wire
